// File: rtl/countdown_6bit.sv
// countdown_6bit: loadable 6-bit down-counter with pause, a terminal-count pulse
// and optional auto-reload from the last loaded value.
module countdown_6bit #(
    parameter int AUTO_RELOAD = 0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [5:0] i_load_val,
    input  logic       i_start,
    input  logic       i_pause,
    output logic [5:0] o_q,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_zero
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     r_state, w_state_nxt;
    logic [5:0] r_q, w_q_nxt, r_reload;
    logic       r_done, w_done_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_q      <= '0;
            r_reload <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_q      <= w_q_nxt;
            r_done   <= w_done_nxt;
            if (i_load) r_reload <= i_load_val;
        end
    end

    // done is registered off the 1->0 step, so a paused zero or a reload never re-fires it
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_done_nxt  = 1'b0;
        if (i_load) begin
            w_q_nxt     = i_load_val;
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: w_state_nxt = (i_start && r_q != 6'd0) ? RUN : IDLE;
                RUN: if (!i_pause) begin
                    if (r_q > 6'd1) begin
                        w_q_nxt = r_q - 6'd1;
                    end else if (r_q == 6'd1) begin
                        w_q_nxt     = 6'd0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = (AUTO_RELOAD != 0) ? RUN : DONE;
                    end else if (AUTO_RELOAD != 0) begin
                        w_q_nxt = r_reload;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign o_q    = r_q;
    assign o_busy = (r_state == RUN);
    assign o_done = r_done;
    assign o_zero = (r_q == 6'd0);
endmodule

// File: tb/tb_countdown_6bit.sv
// tb_countdown_6bit: drives one-shot and auto-reload instances with shared
// stimulus and compares both against a per-edge behavioural model.
module tb_countdown_6bit;
    logic       clk = 1'b0, rst_n = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
    logic [5:0] lv = '0;
    logic [5:0] q0, q1;
    logic       busy0, busy1, done0, done1, zero0, zero1;
    int         n_tot = 0, n_bad = 0;
    int         m_q[2], m_rl[2];
    bit         m_run[2], m_fin[2], m_dn[2], pd[2];

    always #5 clk = ~clk;

    countdown_6bit #(.AUTO_RELOAD(0)) u0 (.i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_load_val(lv),
        .i_start(start), .i_pause(pause), .o_q(q0), .o_busy(busy0), .o_done(done0), .o_zero(zero0));
    countdown_6bit #(.AUTO_RELOAD(1)) u1 (.i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_load_val(lv),
        .i_start(start), .i_pause(pause), .o_q(q1), .o_busy(busy1), .o_done(done1), .o_zero(zero1));

    task automatic check(input string tag, input int got, input int exp);
        n_tot++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic mreset();
        for (int a = 0; a < 2; a++) begin
            m_q[a] = 0; m_rl[a] = 0; m_run[a] = 0; m_fin[a] = 0; m_dn[a] = 0;
        end
    endtask

    task automatic compare();
        check("q0", q0, m_q[0]);       check("q1", q1, m_q[1]);
        check("busy0", busy0, m_run[0]); check("busy1", busy1, m_run[1]);
        check("done0", done0, m_dn[0]);  check("done1", done1, m_dn[1]);
        check("zero0", zero0, m_q[0] == 0); check("zero1", zero1, m_q[1] == 0);
        check("done0_twice", done0 && pd[0], 0);
        check("done1_twice", done1 && pd[1], 0);
        pd[0] = done0; pd[1] = done1;
    endtask

    // One rising edge: advance the model by the spec's per-edge rules, then sample.
    task automatic step();
        @(posedge clk);
        if (!rst_n) mreset();
        else for (int a = 0; a < 2; a++) begin
            if (load) begin
                m_q[a] = lv; m_rl[a] = lv; m_run[a] = 0; m_fin[a] = 0; m_dn[a] = 0;
            end else if (m_fin[a]) begin
                m_fin[a] = 0; m_dn[a] = 0;
            end else if (!m_run[a]) begin
                m_dn[a] = 0;
                if (start && m_q[a] > 0) m_run[a] = 1;
            end else if (pause) begin
                m_dn[a] = 0;
            end else if (m_q[a] > 1) begin
                m_q[a] = m_q[a] - 1; m_dn[a] = 0;
            end else if (m_q[a] == 1) begin
                m_q[a] = 0; m_dn[a] = 1;
                if (a == 0) begin m_run[a] = 0; m_fin[a] = 1; end
            end else begin
                m_dn[a] = 0;
                if (a == 1) m_q[a] = m_rl[a]; else m_run[a] = 0;
            end
        end
        #1 compare();
    endtask

    task automatic drive(input bit l, input int v, input bit s, input bit p);
        load = l; lv = 6'(v); start = s; pause = p;
    endtask

    initial begin
        int exp5[6] = '{5, 4, 3, 2, 1, 0};
        int n, k;
        mreset();
        #1;
        check("rst_q", q0, 0); check("rst_busy", busy1, 0); check("rst_done", done0, 0); check("rst_zero", zero1, 1);
        step(); step();
        rst_n = 1'b1;
        // one-shot from 5
        drive(1, 5, 0, 0); step();
        check("load5_q", q0, 5);
        drive(0, 0, 1, 0); step();
        check("start5_busy", busy0, 1);
        drive(0, 0, 0, 0);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            check("seq5_q", q0, exp5[i]);
            n += done0;
        end
        check("seq5_done_at0", done0, 1);
        step(); n += done0;
        check("seq5_ndone", n, 1); check("seq5_idle", busy0, 0);
        // pause at q = 2 delays done by two edges
        drive(1, 3, 0, 0); step();
        drive(0, 0, 1, 0); step();
        drive(0, 0, 0, 0); step();
        check("p_q2", q0, 2);
        drive(0, 0, 0, 1); step(); check("p_hold1", q0, 2); step(); check("p_hold2", q0, 2);
        check("p_busy", busy0, 1);
        drive(0, 0, 0, 0);
        k = 0;
        while (!done0 && k < 20) begin step(); k++; end
        check("p_done_lat", k, 2);
        // auto-reload period N+1
        drive(1, 2, 0, 0); step();
        drive(0, 0, 1, 0); step();
        drive(0, 0, 0, 0);
        n = 0;
        for (int i = 0; i < 9; i++) begin
            step();
            n += done1;
            check("ar_done_q0", done1, q1 == 0);
        end
        check("ar_ndone", n, 3);
        // zero load: start ignored
        drive(1, 0, 0, 0); step();
        drive(0, 0, 1, 0); step(); step();
        check("z_busy", busy1, 0); check("z_q", q0, 0); check("z_done", done1, 0);
        // abort by load mid-run
        drive(1, 63, 0, 0); step();
        drive(0, 0, 1, 0); step();
        drive(0, 0, 0, 0);
        k = 0;
        while (q0 != 40 && k < 40) begin step(); k++; end
        check("ab_reach40", q0, 40);
        drive(1, 10, 0, 0); step();
        check("ab_q", q0, 10); check("ab_busy", busy0, 0); check("ab_done", done0, 0);
        drive(0, 0, 1, 0); step();
        drive(0, 0, 0, 0);
        for (int i = 0; i < 11; i++) step();
        // async reset mid-run at q = 17
        drive(1, 20, 0, 0); step();
        drive(0, 0, 1, 0); step();
        drive(0, 0, 0, 0);
        k = 0;
        while (q0 != 17 && k < 30) begin step(); k++; end
        check("rs_reach17", q0, 17);
        #2 rst_n = 1'b0; mreset();
        #1 check("rs_q", q0, 0); check("rs_busy", busy0, 0); check("rs_zero", zero0, 1); check("rs_q1", q1, 0);
        step();
        rst_n = 1'b1;
        drive(1, 7, 1, 0); step();
        check("ls_busy", busy0, 0); check("ls_q", q0, 7);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(15) == 0, $urandom_range(63) < 8 ? $urandom_range(3) : $urandom_range(63),
                  $urandom_range(3) == 0, $urandom_range(4) == 0);
            step();
            if ($urandom_range(199) == 0) begin
                #2 rst_n = 1'b0; mreset();
                #1 compare();
                #1 rst_n = 1'b1;
            end
        end
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
